// File: rtl/tick_period_meter.sv
//------------------------------------------------------------------------------
// Module  : tick_period_meter
// Brief   : Synchronises a slow square wave, emits edge pulses, measures the
//           half-period in clk cycles and flags tolerance errors / signal loss.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tick_period_meter #(
   parameter int CNT_W       = 32,
   parameter int EXPECT_HALF = 12_500_001,
   parameter int TOL         = 1000,
   parameter int TIMEOUT     = 25_000_000
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             wave_in,
   output logic             edge_pulse,
   output logic             rise_pulse,
   output logic [CNT_W-1:0] half_period,
   output logic             period_valid,
   output logic             in_tol,
   output logic             timeout
);

   localparam logic [CNT_W-1:0] c_timeout = CNT_W'(TIMEOUT);
   localparam logic [CNT_W:0]   c_expect  = (CNT_W+1)'(EXPECT_HALF);
   localparam logic [CNT_W:0]   c_tol     = (CNT_W+1)'(TOL);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ARMED  = 2'd1,
      LOCKED = 2'd2,
      LOST   = 2'd3
   } state_t;

   state_t           r_state;
   state_t           w_next;
   logic             r_s1;
   logic             r_s2;
   logic             r_s3;
   logic [CNT_W-1:0] r_cnt;
   logic             w_edge;
   logic             w_rise;
   logic             w_at_limit;
   logic             w_measure;
   logic             w_lose;
   logic [CNT_W:0]   w_cnt_x;
   logic [CNT_W:0]   w_diff;
   logic             w_in_tol;

   assign w_edge     = r_s2 ^ r_s3;
   assign w_rise     = r_s2 & ~r_s3;
   assign w_at_limit = (r_cnt == c_timeout);

   // One extra bit keeps the absolute difference free of underflow.
   assign w_cnt_x  = {1'b0, r_cnt};
   assign w_diff   = (w_cnt_x >= c_expect) ? (w_cnt_x - c_expect) : (c_expect - w_cnt_x);
   assign w_in_tol = (w_diff <= c_tol);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   // An edge always wins over a simultaneous timeout.
   always_comb begin
      w_next    = r_state;
      w_measure = 1'b0;
      w_lose    = 1'b0;
      case (r_state)
         IDLE: begin
            if (w_edge) w_next = ARMED;
         end
         ARMED, LOCKED: begin
            if (w_edge) begin
               w_measure = 1'b1;
               w_next    = LOCKED;
            end else if (w_at_limit) begin
               w_lose = 1'b1;
               w_next = LOST;
            end
         end
         LOST: begin
            if (w_edge) w_next = ARMED;
         end
         default: w_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_s1         <= 1'b0;
         r_s2         <= 1'b0;
         r_s3         <= 1'b0;
         r_cnt        <= '0;
         edge_pulse   <= 1'b0;
         rise_pulse   <= 1'b0;
         half_period  <= '0;
         period_valid <= 1'b0;
         in_tol       <= 1'b0;
         timeout      <= 1'b0;
      end else begin
         r_s1       <= wave_in;
         r_s2       <= r_s1;
         r_s3       <= r_s2;
         edge_pulse <= w_edge;
         rise_pulse <= w_rise;

         if (w_edge) begin
            r_cnt <= {{(CNT_W-1){1'b0}}, 1'b1};
         end else if (r_state == IDLE) begin
            r_cnt <= '0;
         end else if (r_cnt < c_timeout) begin
            r_cnt <= r_cnt + 1'b1;
         end

         if (w_measure) begin
            half_period  <= r_cnt;
            in_tol       <= w_in_tol;
            period_valid <= 1'b1;
         end else if (w_lose) begin
            period_valid <= 1'b0;
         end

         if (w_lose) begin
            timeout <= 1'b1;
         end else if ((r_state == LOST) && w_edge) begin
            timeout <= 1'b0;
         end
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_tick_period_meter.sv
//------------------------------------------------------------------------------
// Module  : tb_tick_period_meter
// Brief   : Randomised and directed self-checking bench for tick_period_meter
//           against an event-level model of edge timing and period measurement.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_tick_period_meter;

   localparam int CNT_W       = 8;
   localparam int EXPECT_HALF = 10;
   localparam int TOL         = 1;
   localparam int TIMEOUT     = 40;

   logic             clk;
   logic             rst;
   logic             wave_in;
   logic             edge_pulse;
   logic             rise_pulse;
   logic [CNT_W-1:0] half_period;
   logic             period_valid;
   logic             in_tol;
   logic             timeout;

   int total = 0;
   int bad   = 0;

   tick_period_meter #(
      .CNT_W      (CNT_W),
      .EXPECT_HALF(EXPECT_HALF),
      .TOL        (TOL),
      .TIMEOUT    (TIMEOUT)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .wave_in     (wave_in),
      .edge_pulse  (edge_pulse),
      .rise_pulse  (rise_pulse),
      .half_period (half_period),
      .period_valid(period_valid),
      .in_tol      (in_tol),
      .timeout     (timeout)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string nm, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0d want %0d at %0t", nm, act, exp, $time);
      end
   endtask

   // Event-level model: wave samples taken at each clock; an edge event at
   // clock t exists when the samples from clocks t-2 and t-3 differ.
   int q[$];
   int t_now;
   int m_last;
   bit m_have, m_valid, m_tol, m_tmo, m_ep, m_rp;
   int m_half;

   function automatic int iabs(input int v);
      return (v < 0) ? -v : v;
   endfunction

   task automatic model_reset();
      q = {0, 0, 0, 0};
      m_have  = 1'b0;
      m_valid = 1'b0;
      m_tol   = 1'b0;
      m_tmo   = 1'b0;
      m_ep    = 1'b0;
      m_rp    = 1'b0;
      m_half  = 0;
      m_last  = 0;
   endtask

   task automatic model_step(input logic w);
      bit ev;
      t_now++;
      q.push_front(int'(w));
      void'(q.pop_back());
      ev   = (q[2] != q[3]);
      m_ep = ev;
      m_rp = ev && (q[2] == 1);
      if (ev) begin
         if (m_have) begin
            m_half  = t_now - m_last;
            m_valid = 1'b1;
            m_tol   = (iabs(m_half - EXPECT_HALF) <= TOL);
         end
         m_have = 1'b1;
         m_tmo  = 1'b0;
         m_last = t_now;
      end else if (m_have && (t_now - m_last == TIMEOUT)) begin
         m_have  = 1'b0;
         m_tmo   = 1'b1;
         m_valid = 1'b0;
      end
   endtask

   always @(posedge clk or negedge rst) begin
      if (!rst) begin
         model_reset();
         #1;
         chk("rst_edge",   int'(edge_pulse),   0);
         chk("rst_rise",   int'(rise_pulse),   0);
         chk("rst_half",   int'(half_period),  0);
         chk("rst_valid",  int'(period_valid), 0);
         chk("rst_intol",  int'(in_tol),       0);
         chk("rst_tmo",    int'(timeout),      0);
      end else begin
         model_step(wave_in);
         #1;
         chk("edge_pulse",   int'(edge_pulse),   int'(m_ep));
         chk("rise_pulse",   int'(rise_pulse),   int'(m_rp));
         chk("half_period",  int'(half_period),  m_half);
         chk("period_valid", int'(period_valid), int'(m_valid));
         chk("timeout",      int'(timeout),      int'(m_tmo));
         if (m_valid) chk("in_tol", int'(in_tol), int'(m_tol));
      end
   end

   task automatic hold(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic tg(input int n);
      wave_in = ~wave_in;
      hold(n);
   endtask

   // Toggle and pin the edge-pulse latency (3 clocks) and width (1 clock).
   task automatic tog_chk(input int n);
      logic exp_rise;
      wave_in  = ~wave_in;
      exp_rise = wave_in;
      repeat (3) @(posedge clk);
      #1;
      chk("lat_edge", int'(edge_pulse), 1);
      chk("lat_rise", int'(rise_pulse), int'(exp_rise));
      @(posedge clk);
      #1;
      chk("width_edge", int'(edge_pulse), 0);
      hold(n - 3);
   endtask

   initial begin
      t_now   = 0;
      wave_in = 1'b0;
      rst     = 1'b0;

      // Reset held while the input toggles.
      repeat (4) tg(2);
      rst = 1'b1;
      hold(5);

      // Nominal 10-cycle half-period.
      tog_chk(10);
      chk("arm_only_valid", int'(period_valid), 0);
      tog_chk(10);
      chk("nom_half",  int'(half_period),  10);
      chk("nom_valid", int'(period_valid), 1);
      chk("nom_intol", int'(in_tol),       1);
      repeat (4) tog_chk(10);

      // Off-tolerance then back inside tolerance.
      repeat (3) tg(12);
      chk("off_half",  int'(half_period),  12);
      chk("off_intol", int'(in_tol),       0);
      chk("off_valid", int'(period_valid), 1);
      repeat (3) tg(9);
      chk("nine_half",  int'(half_period), 9);
      chk("nine_intol", int'(in_tol),      1);

      // Loss and recovery.
      repeat (3) tg(10);
      hold(60);
      chk("lost_tmo",   int'(timeout),      1);
      chk("lost_valid", int'(period_valid), 0);
      chk("lost_half",  int'(half_period),  10);
      tg(10);
      chk("rearm_tmo",   int'(timeout),      0);
      chk("rearm_valid", int'(period_valid), 0);
      tg(10);
      chk("relock_valid", int'(period_valid), 1);
      chk("relock_half",  int'(half_period),  10);

      // Edge exactly at the timeout boundary.
      tg(40);
      tg(5);
      chk("bnd_half",  int'(half_period),  40);
      chk("bnd_intol", int'(in_tol),       0);
      chk("bnd_tmo",   int'(timeout),      0);
      chk("bnd_valid", int'(period_valid), 1);

      // Asynchronous reset mid-count while locked.
      tg(10);
      tg(10);
      tg(5);
      chk("pre_rst_valid", int'(period_valid), 1);
      #2 rst = 1'b0;
      #1;
      chk("async_valid", int'(period_valid), 0);
      chk("async_half",  int'(half_period),  0);
      wave_in = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      hold(5);
      tg(10);
      chk("post_rst_arm", int'(period_valid), 0);
      tg(10);
      chk("post_rst_valid", int'(period_valid), 1);
      chk("post_rst_half",  int'(half_period),  10);

      // Randomised intervals with occasional mid-cycle resets.
      for (int i = 0; i < 150; i++) begin
         tg(int'($urandom_range(1, 45)));
         if ($urandom_range(0, 19) == 0) begin
            #3 rst = 1'b0;
            #4;
            wave_in = 1'($urandom_range(0, 1));
            @(negedge clk);
            rst = 1'b1;
         end
      end
      hold(50);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/tick_period_meter.md
Name: tick_period_meter

Overview:
- Receive-side companion to the slow clock dividers.
- Takes a slow square wave (for example the 2 Hz divider output, or an external sensor/blink line), synchronises it into the system clock domain and emits one-cycle edge pulses.
- Measures the half-period in system clocks, checks it against an expected value and flags loss of signal.
- Used for self-check of divider outputs and as a clean tick source for downstream timers and state machines.

Parameters:
- CNT_W, 32, width of the measurement counter and the half_period output.
- EXPECT_HALF, 12_500_001, expected half-period in clk cycles. This matches a divider that toggles after its counter reaches 12_500_000.
- TOL, 1000, allowed absolute deviation from EXPECT_HALF, in cycles.
- TIMEOUT, 25_000_000, number of cycles without an edge after which the signal is declared lost. Must satisfy TIMEOUT < 2^CNT_W and TIMEOUT > EXPECT_HALF + TOL.

Ports:
- clk  in  1  system clock; all logic on posedge.
- rst  in  1  asynchronous, active-low reset (rst = 0 clears the block immediately).
- wave_in  in  1  asynchronous slow square wave.
- edge_pulse  out  1  one-cycle pulse per detected edge of either polarity.
- rise_pulse  out  1  one-cycle pulse per detected rising edge.
- half_period  out  CNT_W  cycles between the last two accepted edges.
- period_valid  out  1  half_period holds a valid measurement.
- in_tol  out  1  |half_period - EXPECT_HALF| <= TOL. Meaningful only while period_valid = 1.
- timeout  out  1  signal lost; sticky until the next edge.

Behaviour:
- Reset (rst = 0, asynchronous):
  - s1, s2, s3, cnt, half_period, edge_pulse, rise_pulse, period_valid, in_tol and timeout all go to 0.
  - State goes to IDLE.
- Synchroniser and edge detect:
  - Registers s1 <= wave_in, s2 <= s1, s3 <= s2.
  - Internal edge = s2 ^ s3; rise = s2 & ~s3.
  - edge_pulse and rise_pulse are registered copies of edge and rise.
  - A wave_in change captured by s1 at clock k gives edge_pulse high during the cycle after clock k+2, for exactly 1 cycle.
- Counter:
  - cnt counts clocks since the last edge.
  - On a cycle with edge = 1: cnt <= 1.
  - Otherwise, if cnt < TIMEOUT: cnt <= cnt + 1.
  - cnt saturates at TIMEOUT and never wraps.
  - Two edges D cycles apart give cnt = D on the second edge cycle.
- FSM states: IDLE, ARMED, LOCKED, LOST.
  - IDLE:
    - cnt held at 0.
    - edge -> ARMED (no measurement taken).
  - ARMED:
    - edge -> half_period <= cnt, period_valid <= 1, in_tol updated, next state LOCKED.
    - cnt == TIMEOUT with no edge -> LOST.
  - LOCKED:
    - edge -> half_period <= cnt, in_tol updated, stay in LOCKED.
    - cnt == TIMEOUT with no edge -> LOST.
  - LOST:
    - On entry: timeout <= 1, period_valid <= 0; half_period keeps its last value.
    - edge -> timeout <= 0, next state ARMED. The interval that timed out is discarded.
- in_tol:
  - Registered in the same cycle as half_period from cnt.
  - Uses the absolute difference computed at CNT_W+1 bits, so there is no underflow when cnt < EXPECT_HALF.
- Simultaneous events: an edge in the same cycle that cnt reaches TIMEOUT counts as an edge; no timeout is raised.
- Reset mid-measurement: everything is cleared at once. After release the block starts in IDLE, and the first edge only arms it.
- A wave_in pulse shorter than one clk period may be missed. This is acceptable; no glitch filtering is required.

Test Plan (bench params: EXPECT_HALF = 10, TOL = 1, TIMEOUT = 40, CNT_W = 8):
1. Reset: hold rst = 0 with wave_in toggling.
   - Required: all outputs 0.
   - Assert rst = 0 asynchronously between clock edges; outputs must clear without waiting for a clock edge.
2. Nominal signal: release rst, then toggle wave_in every 10 clocks.
   - First edge: edge_pulse only, period_valid stays 0.
   - Second edge: half_period = 10, period_valid = 1, in_tol = 1.
   - Each edge_pulse is 1 cycle wide and appears 3 clocks after wave_in changes.
   - rise_pulse fires on rising edges only.
3. Off-tolerance: after locking, toggle every 12 clocks.
   - Required: half_period = 12, in_tol = 0, period_valid = 1.
   - Return to toggling every 9 clocks: in_tol = 1.
4. Loss and recovery: after locking, hold wave_in for 60 clocks.
   - Required: timeout = 1 and period_valid = 0 exactly when cnt reaches 40; half_period is unchanged.
   - Next edge: timeout = 0, still not valid.
   - Following edge 10 clocks later: period_valid = 1, half_period = 10.
5. Boundary: place an edge exactly 40 cycles after the previous one.
   - Required: no timeout, half_period = 40, in_tol = 0.
6. Reset mid-count: apply rst = 0 pulse 5 clocks after an edge while LOCKED.
   - Required: immediate clear.
   - Next edge only arms; the one after that gives a correct half_period.
